// File: rtl/amradio_wd_pkg.sv
// Shared definitions for the heartbeat generator and the watchdog it feeds:
// state enumeration and default configuration widths/limits.
package amradio_wd_pkg;

    localparam int PERIOD_W_DEF = 32;  // width of beat-interval config and timer
    localparam int MISS_MAX_DEF = 3;   // consecutive misses before stalling
    localparam int MISS_W       = 4;   // width of the miss counter
    localparam int HB_COUNT_W   = 16;  // width of the issued-beat counter

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2
    } hb_state_e;

endpackage

// File: rtl/hb_interval_timer.sv
// Down-counting interval timer: loads a value on request, decrements on
// request, and flags when it has reached zero.
module hb_interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load has priority over decrement; never wraps below zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge values of its sources, independent of block order.
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/heartbeat_generator.sv
// Heartbeat generator: issues a registered single-cycle beat to the watchdog
// once per interval, but only if the monitored DSP path showed liveness.
// Repeated silent intervals stall the block until liveness reappears.
module heartbeat_generator
    import amradio_wd_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int MISS_MAX = MISS_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  alive_strobe,
    input  logic                  wd_warning,
    output logic                  heartbeat,
    output logic                  stalled,
    output logic [HB_COUNT_W-1:0] hb_count
);

    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MISS_MAX);

    hb_state_e             state_q, state_d;
    logic                  alive_seen_q, alive_seen_d;
    logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic                  heartbeat_q, heartbeat_d;
    logic [HB_COUNT_W-1:0] hb_count_q, hb_count_d;

    logic                  tmr_load;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic [PERIOD_W-1:0]   reload_value;
    logic                  live;
    logic                  eval;
    logic [MISS_W-1:0]     miss_inc;

    // Reload value is max(period, 2) - 1, so an interval is never shorter
    // than two cycles and a beat can never follow a beat directly.
    always_comb begin
        reload_value = period - PERIOD_W'(1);
        if (period < PERIOD_W'(2)) begin
            reload_value = PERIOD_W'(1);
        end
    end

    // Liveness is either remembered from earlier in the interval or arriving
    // now. An early (warning) evaluation is ignored in the cycle the beat is
    // on the output, keeping beats at least one idle cycle apart.
    assign live     = alive_seen_q | alive_strobe;
    assign eval     = tmr_zero | (wd_warning & ~heartbeat_q);
    assign miss_inc = miss_cnt_q + MISS_W'(1);

    hb_interval_timer #(
        .WIDTH (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load       (tmr_load),
        .load_value (reload_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // Next-state, beat evaluation and timer control.
    always_comb begin
        state_d      = state_q;
        alive_seen_d = alive_seen_q;
        miss_cnt_d   = miss_cnt_q;
        heartbeat_d  = 1'b0;
        hb_count_d   = hb_count_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_RUN;
                    tmr_load     = 1'b1;
                    alive_seen_d = 1'b0;
                    miss_cnt_d   = '0;
                end
                ST_RUN: begin
                    if (eval && live) begin
                        // Beat: one evaluation even if timer and warning coincide.
                        heartbeat_d  = 1'b1;
                        hb_count_d   = hb_count_q + HB_COUNT_W'(1);
                        miss_cnt_d   = '0;
                        alive_seen_d = 1'b0;
                        tmr_load     = 1'b1;
                    end else if (tmr_zero) begin
                        // Interval expired without liveness: count a miss.
                        miss_cnt_d   = miss_inc;
                        alive_seen_d = 1'b0;
                        tmr_load     = 1'b1;
                        if (miss_inc >= MISS_LIMIT) begin
                            state_d = ST_STALLED;
                        end
                    end else begin
                        // Mid-interval (or silent warning): keep counting.
                        tmr_dec      = 1'b1;
                        alive_seen_d = live;
                    end
                end
                ST_STALLED: begin
                    if (alive_strobe) begin
                        state_d      = ST_RUN;
                        tmr_load     = 1'b1;
                        miss_cnt_d   = '0;
                        alive_seen_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset overrides every other input on its edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            alive_seen_q <= 1'b0;
            miss_cnt_q   <= '0;
            heartbeat_q  <= 1'b0;
            hb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alive_seen_q <= alive_seen_d;
            miss_cnt_q   <= miss_cnt_d;
            heartbeat_q  <= heartbeat_d;
            hb_count_q   <= hb_count_d;
        end
    end

    assign heartbeat = heartbeat_q;
    assign stalled   = (state_q == ST_STALLED);
    assign hb_count  = hb_count_q;

endmodule

// File: tb/tb_heartbeat_generator.sv
// Self-checking bench for heartbeat_generator: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_heartbeat_generator;

    localparam int PW = 32;
    localparam int MM = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic [PW-1:0] period;
    logic          alive_strobe;
    logic          wd_warning;
    logic          heartbeat;
    logic          stalled;
    logic [15:0]   hb_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: mode 0=idle 1=run 2=stalled; m_left = cycles left
    // before the interval expires.
    int     m_mode = 0;
    longint m_left = 0;
    bit     m_seen = 0;
    int     m_miss = 0;
    bit     m_hb   = 0;
    int     m_cnt  = 0;

    heartbeat_generator #(
        .PERIOD_W (PW),
        .MISS_MAX (MM)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .period       (period),
        .alive_strobe (alive_strobe),
        .wd_warning   (wd_warning),
        .heartbeat    (heartbeat),
        .stalled      (stalled),
        .hb_count     (hb_count)
    );

    always #5 clk = ~clk;

    function automatic longint eff_period(input logic [PW-1:0] p);
        return (p < 2) ? 2 : longint'(p);
    endfunction

    task automatic model_step();
        bit     hb_prev, live, ev_t, ev_w;
        longint e;
        e = eff_period(period);
        if (!rstn) begin
            m_mode = 0; m_hb = 0; m_cnt = 0; m_left = 0; m_miss = 0; m_seen = 0;
        end else if (!enable) begin
            m_mode = 0; m_hb = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_left = e - 1; m_seen = 0; m_miss = 0; m_hb = 0;
        end else if (m_mode == 1) begin
            hb_prev = m_hb;
            m_hb    = 0;
            live    = m_seen || alive_strobe;
            ev_t    = (m_left == 0);
            ev_w    = wd_warning && !hb_prev;
            if ((ev_t || ev_w) && live) begin
                m_hb = 1; m_cnt = (m_cnt + 1) % 65536;
                m_miss = 0; m_seen = 0; m_left = e - 1;
            end else if (ev_t) begin
                m_miss++; m_seen = 0; m_left = e - 1;
                if (m_miss >= MM) m_mode = 2;
            end else begin
                m_seen = live; m_left--;
            end
        end else begin
            m_hb = 0;
            if (alive_strobe) begin
                m_mode = 1; m_left = e - 1; m_miss = 0; m_seen = 0;
            end
        end
    endtask

    // One clock edge: DUT and model advance together; outputs settle by +1.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        alive_strobe = 1'b0;
        wd_warning   = 1'b0;
    endtask

    // Reset then enable: returns one cycle after the edge entering RUN.
    task automatic restart(input logic [PW-1:0] p);
        idle_inputs();
        rstn = 1'b0; enable = 1'b0; period = p;
        tick();
        rstn = 1'b1; enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0; enable = 1'b1; period = 10; alive_strobe = 1'b1; wd_warning = 1'b1;
        tick(); tick();
        n_cmp++; if (heartbeat !== 1'b0) begin n_err++; $display("FAIL reset_hb: got %b want 0", heartbeat); end
        n_cmp++; if (stalled !== 1'b0) begin n_err++; $display("FAIL reset_stalled: got %b want 0", stalled); end
        n_cmp++; if (hb_count !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", hb_count); end
    endtask

    task automatic test_steady();
        int last, beats;
        restart(10);
        last = 0; beats = 0;
        for (int i = 1; i <= 50; i++) begin
            alive_strobe = (i % 4 == 1);
            tick();
            n_cmp++; if (heartbeat !== m_hb) begin n_err++; $display("FAIL steady_hb cyc %0d: got %b want %b", i, heartbeat, m_hb); end
            if (heartbeat === 1'b1) begin
                beats++;
                n_cmp++; if (i - last != 10) begin n_err++; $display("FAIL steady_gap: got %0d want 10", i - last); end
                last = i;
            end
        end
        n_cmp++; if (beats != 5) begin n_err++; $display("FAIL steady_beats: got %0d want 5", beats); end
        n_cmp++; if (hb_count !== 16'd5) begin n_err++; $display("FAIL steady_cnt: got %0d want 5", hb_count); end
        idle_inputs();
    endtask

    task automatic test_stall();
        restart(10);
        for (int i = 1; i <= 29; i++) begin
            tick();
            n_cmp++; if (heartbeat !== 1'b0) begin n_err++; $display("FAIL stall_hb cyc %0d: got %b want 0", i, heartbeat); end
        end
        n_cmp++; if (stalled !== 1'b0) begin n_err++; $display("FAIL stall_early: got %b want 0", stalled); end
        tick();
        n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL stall_at30: got %b want 1", stalled); end
        tick(); tick();
        n_cmp++; if (stalled !== 1'b1 || heartbeat !== 1'b0) begin n_err++; $display("FAIL stall_hold: got st=%b hb=%b want st=1 hb=0", stalled, heartbeat); end
        alive_strobe = 1'b1;
        tick();
        alive_strobe = 1'b0;
        n_cmp++; if (stalled !== 1'b0 || heartbeat !== 1'b0) begin n_err++; $display("FAIL stall_exit: got st=%b hb=%b want st=0 hb=0", stalled, heartbeat); end
        for (int i = 1; i <= 10; i++) begin
            alive_strobe = (i == 3);
            tick();
            n_cmp++; if (heartbeat !== (i == 10)) begin n_err++; $display("FAIL stall_rebeat cyc %0d: got %b want %b", i, heartbeat, (i == 10)); end
        end
        idle_inputs();
    endtask

    task automatic test_wd_early();
        restart(100);
        for (int k = 1; k <= 125; k++) begin
            alive_strobe = (k == 6) || (k == 60);
            wd_warning   = (k == 21);
            tick();
            n_cmp++;
            if (heartbeat !== ((k == 21) || (k == 121))) begin
                n_err++; $display("FAIL wd_early cyc %0d: got %b want %b", k, heartbeat, (k == 21) || (k == 121));
            end
        end
        n_cmp++; if (hb_count !== 16'd2) begin n_err++; $display("FAIL wd_cnt: got %0d want 2", hb_count); end
        idle_inputs();
    endtask

    task automatic test_short_period();
        logic prev;
        int   last;
        for (int p = 0; p < 2; p++) begin
            restart(PW'(p));
            prev = 1'b0; last = 0;
            for (int i = 1; i <= 40; i++) begin
                alive_strobe = 1'b1;
                wd_warning   = (i > 20) ? 1'($urandom % 2) : 1'b0;
                tick();
                n_cmp++; if (heartbeat !== m_hb) begin n_err++; $display("FAIL short_hb p=%0d cyc %0d: got %b want %b", p, i, heartbeat, m_hb); end
                n_cmp++; if (prev && heartbeat) begin n_err++; $display("FAIL short_adjacent p=%0d cyc %0d: got 1 want 0", p, i); end
                if (heartbeat === 1'b1 && i <= 20) begin
                    n_cmp++; if (i - last != 2) begin n_err++; $display("FAIL short_gap p=%0d: got %0d want 2", p, i - last); end
                    last = i;
                end
                prev = heartbeat;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        restart(10);
        alive_strobe = 1'b1;
        for (int i = 1; i <= 15; i++) tick();
        rstn = 1'b0; wd_warning = 1'b1;
        tick();
        n_cmp++; if (heartbeat !== 1'b0 || stalled !== 1'b0 || hb_count !== 16'h0) begin
            n_err++; $display("FAIL midreset: got hb=%b st=%b cnt=%h want 0/0/0000", heartbeat, stalled, hb_count);
        end
        rstn = 1'b1; wd_warning = 1'b0;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (heartbeat !== (i == 10)) begin n_err++; $display("FAIL midreset_restart cyc %0d: got %b want %b", i, heartbeat, (i == 10)); end
        end
        enable = 1'b0;
        tick();
        n_cmp++; if (heartbeat !== 1'b0 || stalled !== 1'b0 || hb_count !== 16'd1) begin
            n_err++; $display("FAIL disable_run: got hb=%b st=%b cnt=%0d want 0/0/1", heartbeat, stalled, hb_count);
        end
        enable = 1'b1; period = 3; alive_strobe = 1'b0;
        for (int i = 0; i <= 9; i++) tick();
        n_cmp++; if (stalled !== 1'b1) begin n_err++; $display("FAIL disable_prestall: got %b want 1", stalled); end
        enable = 1'b0;
        tick();
        n_cmp++; if (stalled !== 1'b0 || hb_count !== 16'd1) begin
            n_err++; $display("FAIL disable_stall: got st=%b cnt=%0d want 0/1", stalled, hb_count);
        end
        enable = 1'b1; period = 10; alive_strobe = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (heartbeat !== (i == 10)) begin n_err++; $display("FAIL reenable cyc %0d: got %b want %b", i, heartbeat, (i == 10)); end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [15:0] seen [2];
        int          nb;
        idle_inputs();
        rstn = 1'b1; enable = 1'b0; period = 2;
        tick();
        force dut.hb_count_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #2;
        release dut.hb_count_q;
        tick();
        enable = 1'b1; alive_strobe = 1'b1;
        tick();
        nb = 0;
        seen[0] = 16'h1234; seen[1] = 16'h1234;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (heartbeat === 1'b1 && nb < 2) begin
                seen[nb] = hb_count;
                nb++;
            end
        end
        n_cmp++; if (seen[0] !== 16'hFFFF) begin n_err++; $display("FAIL wrap_first: got %h want ffff", seen[0]); end
        n_cmp++; if (seen[1] !== 16'h0000) begin n_err++; $display("FAIL wrap_second: got %h want 0000", seen[1]); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic prev;
        prev = 1'b0;
        restart(5);
        for (int i = 0; i < 3000; i++) begin
            rstn         = ($urandom % 300) != 0;
            enable       = ($urandom % 150) != 0;
            if ($urandom % 60 == 0) period = PW'($urandom % 13);
            alive_strobe = ($urandom % 6) == 0;
            wd_warning   = ($urandom % 9) == 0;
            tick();
            n_cmp++; if (heartbeat !== m_hb) begin n_err++; $display("FAIL rand_hb cyc %0d: got %b want %b", i, heartbeat, m_hb); end
            n_cmp++; if (stalled !== (m_mode == 2)) begin n_err++; $display("FAIL rand_stalled cyc %0d: got %b want %b", i, stalled, (m_mode == 2)); end
            n_cmp++; if (hb_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rand_cnt cyc %0d: got %0d want %0d", i, hb_count, m_cnt); end
            n_cmp++; if (prev && heartbeat) begin n_err++; $display("FAIL rand_adjacent cyc %0d: got 1 want 0", i); end
            prev = heartbeat;
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; period = '0;
        idle_inputs();
        test_reset();
        test_steady();
        test_stall();
        test_wd_early();
        test_short_period();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/heartbeat_generator.md
HEARTBEAT_GENERATOR -- requirements
Module: heartbeat_generator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (clock), rstn (reset), both 1-bit inputs; all state SHALL update on posedge clk only.
REQ-002 Parameter PERIOD_W, default 32: width of the beat-interval configuration and timer.
REQ-003 Parameter MISS_MAX, default 3: consecutive missed beats before the block stalls; legal range 1..15.
REQ-004 clk  input  1  system clock.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 enable  input  1  run request; 0 forces IDLE.
REQ-007 period  input  PERIOD_W  beat interval in cycles; sampled on every timer reload.
REQ-008 alive_strobe  input  1  single-cycle liveness pulse from the monitored DSP path.
REQ-009 wd_warning  input  1  watchdog warning; requests an early beat.
REQ-010 heartbeat  output  1  single-cycle, registered beat pulse to the watchdog's heartbeat input.
REQ-011 stalled  output  1  high while in STALLED.
REQ-012 hb_count  output  16  number of beats issued; wraps from 0xFFFF to 0x0000.

Function
REQ-013 States SHALL be IDLE, RUN and STALLED.
REQ-014 Effective period SHALL be max(period, 2); the timer SHALL load effective period minus 1 and decrement once per cycle in RUN.
REQ-015 IDLE with enable=1 SHALL go to RUN on the next edge, load the timer and clear alive_seen and miss_cnt.
REQ-016 In RUN, alive_seen SHALL be set by alive_strobe and cleared on each beat evaluation.
REQ-017 A beat evaluation SHALL occur in the cycle the timer equals 0, or in any RUN cycle where wd_warning=1.
REQ-018 At evaluation with alive_seen=1 or alive_strobe=1: heartbeat=1 on the next cycle, hb_count increments, miss_cnt clears, and the timer reloads.
REQ-019 At a timer-0 evaluation with no liveness: no beat, miss_cnt increments, and the timer reloads; if miss_cnt reaches MISS_MAX, the next state SHALL be STALLED.
REQ-020 A wd_warning evaluation with no liveness SHALL do nothing: no beat, no miss, no reload.
REQ-021 When timer=0 and wd_warning=1 occur in the same cycle, exactly one evaluation SHALL take place.
REQ-022 In STALLED: heartbeat=0 and stalled=1; alive_strobe=1 SHALL return the block to RUN on the next edge with the timer reloaded and miss_cnt=0, and no beat SHALL be issued that cycle.
REQ-023 enable=0 in any state SHALL go to IDLE on the next edge, force heartbeat=0 and stalled=0, and hold hb_count.
REQ-024 heartbeat SHALL never be high for two consecutive cycles.

Reset
REQ-025 While rstn=0 at posedge clk: state=IDLE, heartbeat=0, stalled=0, hb_count=0, timer=0, miss_cnt=0, alive_seen=0.
REQ-026 Reset asserted mid-interval or mid-pulse SHALL override all other inputs on that edge.
REQ-027 Operation SHALL resume per REQ-015 on the first edge with rstn=1 and enable=1.

Structure
REQ-028 A shared package amradio_wd_pkg SHALL hold the state enumeration and the PERIOD_W and MISS_MAX defaults; the watchdog uses the same package.
REQ-029 The timer SHALL be a sub-module hb_interval_timer with inputs load, load_value and dec, and output zero.
REQ-030 miss_cnt SHALL be 4 bits wide.

Verification
REQ-031 Reset, then enable=1 and period=10, with alive_strobe pulsed every 4 cycles -> heartbeat pulses exactly every 10 cycles, and hb_count=5 after 50 RUN cycles.
REQ-032 period=10 with no alive_strobe -> no heartbeat, and stalled=1 after 3 intervals (30 cycles); a single alive_strobe -> stalled=0 on the next cycle, then the next beat 10 cycles later if liveness is seen.
REQ-033 period=100, alive_strobe at cycle 5, wd_warning at cycle 20 -> heartbeat at cycle 21, and the timer restarts so the next beat falls 100 cycles later.
REQ-034 period=0 and period=1 -> the beat interval is 2 cycles, and heartbeat is never high on adjacent cycles.
REQ-035 rstn=0 for one cycle mid-interval, and separately enable=0 -> all outputs return to reset values (hb_count held for enable=0), and the first beat after restart comes one full period later.
REQ-036 hb_count preset near wrap, 2 beats issued -> hb_count reads 0xFFFF then 0x0000.
